// File: rtl/mag_sqrt_feeder.sv
// mag_sqrt_feeder: front end of the float square-root stage in the FFT
// magnitude path. Walks the bin RAM and forms re^2+im^2 as an integer.
// Each sum goes to the sqrt unit as an IEEE-754 single (exact up to 24
// significant bits, truncated beyond that). Every returned magnitude is
// written to the magnitude buffer.
//
// Ports:
//   clk, n_reset          rising-edge clock, synchronous active-low reset
//   go / busy / frame_done frame control and status
//   bin_addr, bin_re/im   bin RAM read port (data one cycle after address)
//   sqrt_start/arg/result/done  handshake with the sqrt unit (done = idle)
//   mag_we/addr/data      magnitude buffer write port
//   err_timeout           sticky sqrt-timeout flag, cleared by accepted go
module mag_sqrt_feeder #(
  parameter int W       = 16,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              go,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] bin_addr,
  input  logic [W-1:0]      bin_re,
  input  logic [W-1:0]      bin_im,
  output logic              sqrt_start,
  output logic [31:0]       sqrt_arg,
  input  logic [31:0]       sqrt_result,
  input  logic              sqrt_done,
  output logic              mag_we,
  output logic [ADDR_W-1:0] mag_addr,
  output logic [31:0]       mag_data,
  output logic              err_timeout
);

  localparam int SW = 2 * W;                 // width of re^2+im^2
  localparam int NW = (SW > 24) ? SW : 24;   // normalisation width
  localparam int PW = $clog2(SW);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [3:0] {
    IDLE, FETCH, LATCH, SQUARE, CONVERT, START, WAIT_LOW, WAIT_HIGH, WRITE, NEXT
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] idx;
  logic signed [W-1:0] re_q, im_q;
  logic signed [SW-1:0] re_sq, im_sq;
  logic [SW-1:0] sq;
  logic [CW-1:0] wcnt;
  logic tmo, in_wait, timeout_hit, last_bin;
  logic [PW-1:0] msb;
  logic [NW-1:0] shifted;
  logic [7:0]  expo;
  logic [22:0] mant;
  logic [31:0] conv;

  // Squares of sign-extended operands; both are non-negative and fit in SW
  // bits as signed, and their sum (max 2^(SW-1)) fits as unsigned.
  assign re_sq = $signed({{W{re_q[W-1]}}, re_q}) * $signed({{W{re_q[W-1]}}, re_q});
  assign im_sq = $signed({{W{im_q[W-1]}}, im_q}) * $signed({{W{im_q[W-1]}}, im_q});

  // Integer -> float: locate the leading one, shift it to the top, and take
  // the 23 bits below it (zero-filled from below, low bits dropped above).
  always_comb begin
    msb = '0;
    for (int i = 0; i < SW; i++)
      if (sq[i]) msb = PW'(i);
    shifted = NW'(sq) << (NW - 1 - int'(msb));
    mant    = 23'(shifted >> (NW - 24));
    expo    = 8'd127 + 8'(msb);
    conv    = {1'b0, expo, mant};
  end

  assign last_bin = (idx == {ADDR_W{1'b1}});
  assign in_wait  = (state == START) || (state == WAIT_LOW) || (state == WAIT_HIGH);
  assign tmo      = (wcnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:      if (go) state_next = FETCH;
      FETCH:     state_next = LATCH;
      LATCH:     state_next = SQUARE;
      SQUARE:    state_next = CONVERT;
      CONVERT:   state_next = (sq == '0) ? WRITE : START;
      START:     if (sqrt_done) state_next = WAIT_LOW;
                 else if (tmo) begin state_next = WRITE; timeout_hit = 1'b1; end
      WAIT_LOW:  if (!sqrt_done) state_next = WAIT_HIGH;
                 else if (tmo) begin state_next = WRITE; timeout_hit = 1'b1; end
      WAIT_HIGH: if (sqrt_done) state_next = WRITE;
                 else if (tmo) begin state_next = WRITE; timeout_hit = 1'b1; end
      WRITE:     state_next = NEXT;
      NEXT:      state_next = last_bin ? IDLE : FETCH;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= IDLE;
      idx         <= '0;
      re_q        <= '0;
      im_q        <= '0;
      sq          <= '0;
      wcnt        <= '0;
      sqrt_arg    <= '0;
      mag_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_next;
      // Wait counter restarts whenever the state changes, so it is fresh on
      // entry to each of the three sqrt wait states.
      if (state_next != state) wcnt <= '0;
      else if (in_wait && !tmo) wcnt <= wcnt + 1'b1;

      if (timeout_hit) begin
        err_timeout <= 1'b1;
        mag_data    <= QNAN;
      end

      case (state)
        IDLE:    if (go) begin idx <= '0; err_timeout <= 1'b0; end
        LATCH:   begin re_q <= $signed(bin_re); im_q <= $signed(bin_im); end
        SQUARE:  sq <= $unsigned(re_sq) + $unsigned(im_sq);
        CONVERT: if (sq == '0) mag_data <= '0;
                 else sqrt_arg <= conv;
        WAIT_HIGH: if (sqrt_done) mag_data <= sqrt_result;
        NEXT:    if (!last_bin) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign bin_addr   = idx;
  assign mag_addr   = idx;
  assign mag_we     = (state == WRITE);
  assign frame_done = (state == NEXT) && last_bin;
  assign sqrt_start = (state == START) && sqrt_done;

endmodule

// File: tb/tb_mag_sqrt_feeder.sv
// Bench for mag_sqrt_feeder: bin RAM model, behavioural sqrt unit, a
// write monitor against a real-arithmetic reference, and directed frames.
module tb_mag_sqrt_feeder;
  localparam int W = 16, AW = 6, N = 64, TMO = 100, LAT = 40;

  logic clk = 1'b0, n_reset = 1'b0, go = 1'b0;
  logic busy, frame_done, sqrt_start, mag_we, err_timeout, sqrt_done;
  logic [AW-1:0] bin_addr, mag_addr;
  logic [W-1:0] bin_re, bin_im;
  logic [31:0] sqrt_arg, sqrt_result, mag_data;

  mag_sqrt_feeder #(.W(W), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .n_reset(n_reset), .go(go), .busy(busy), .frame_done(frame_done),
    .bin_addr(bin_addr), .bin_re(bin_re), .bin_im(bin_im),
    .sqrt_start(sqrt_start), .sqrt_arg(sqrt_arg), .sqrt_result(sqrt_result),
    .sqrt_done(sqrt_done), .mag_we(mag_we), .mag_addr(mag_addr),
    .mag_data(mag_data), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  logic signed [W-1:0] re_mem [N];
  logic signed [W-1:0] im_mem [N];
  always @(posedge clk) begin
    bin_re <= re_mem[bin_addr];
    bin_im <= im_mem[bin_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  int wr_cnt = 0, starts = 0, frames = 0, tot_we = 0;
  int wcyc [N];
  logic [31:0] arg_seen [N];
  logic [31:0] data_seen [N];
  logic prev_we = 1'b0;
  bit stuck_frame = 1'b0;
  logic [31:0] model_arg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint s_of(input int a);
    longint r, i;
    r = re_mem[a];
    i = im_mem[a];
    return r * r + i * i;
  endfunction

  // Single-precision bits of s, truncated: go through a double (exact for
  // s < 2^53) and keep the top 23 fraction bits.
  function automatic logic [31:0] ref_f(input longint s);
    logic [63:0] d;
    int e;
    if (s == 0) return 32'h0;
    d = $realtobits(real'(s));
    e = int'(d[62:52]) - 1023 + 127;
    return {1'b0, e[7:0], d[51:29]};
  endfunction

  // Stand-in sqrt: exact for the 3-4-5 case, an arbitrary bijection elsewhere.
  function automatic logic [31:0] sq_model(input logic [31:0] a);
    return (a == 32'h41C8_0000) ? 32'h40A0_0000 : (a ^ 32'h0055_AA00);
  endfunction

  function automatic logic [31:0] exp_mag(input int k);
    if (s_of(k) == 0) return 32'h0;
    if (stuck_frame) return 32'h7FC0_0000;
    return sq_model(ref_f(s_of(k)));
  endfunction

  function automatic int nz_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (s_of(i) != 0) c++;
    return c;
  endfunction

  task automatic fill();
    logic signed [W-1:0] r, m;
    for (int i = 0; i < N; i++) begin
      r = W'($urandom);
      m = W'($urandom);
      re_mem[i] = r >>> $urandom_range(0, 15);
      im_mem[i] = m >>> $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) begin re_mem[i] = '0; im_mem[i] = '0; end
    end
  endtask

  task automatic run_frame(input bit stuck);
    stuck_frame = stuck;
    wr_cnt = 0;
    starts = 0;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    chk("busy_after_go", 32'(busy), 32'd1);
    chk("err_cleared_by_go", 32'(err_timeout), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int f0, i;
    f0 = frames;
    i = 0;
    while (frames == f0 && i < budget) begin @(negedge clk); i++; end
    chk("frame_done_seen", 32'(frames - f0), 32'd1);
    chk("write_count", 32'(wr_cnt), 32'(N));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_mag_we"}, 32'(mag_we), 0);
    chk({tag, "_sqrt_start"}, 32'(sqrt_start), 0);
    chk({tag, "_sqrt_arg"}, sqrt_arg, 0);
    chk({tag, "_mag_data"}, mag_data, 0);
    chk({tag, "_err"}, 32'(err_timeout), 0);
    chk({tag, "_bin_addr"}, 32'(bin_addr), 0);
    chk({tag, "_mag_addr"}, 32'(mag_addr), 0);
  endtask

  initial begin
    int f0, w0, k, i;
    sqrt_done = 1'b1;
    sqrt_result = '0;
    fill();
    fork
      // sqrt unit: drops done after accepting start, raises it LAT cycles
      // later with the result; when stuck it stays busy until released.
      forever begin
        @(negedge clk);
        if (n_reset && sqrt_start) begin
          model_arg = sqrt_arg;
          @(posedge clk); #1 sqrt_done = 1'b0;
          if (!stuck_frame) repeat (LAT) @(posedge clk);
          else while (stuck_frame) @(posedge clk);
          #1 sqrt_result = sq_model(model_arg);
          sqrt_done = 1'b1;
        end
      end
      // write / start / frame_done monitor
      forever begin
        @(negedge clk);
        if (n_reset) begin
          if (sqrt_start) begin
            k = wr_cnt % N;
            starts++;
            chk("sqrt_arg", sqrt_arg, ref_f(s_of(k)));
            chk("start_on_nonzero_bin", 32'(s_of(k) != 0), 32'd1);
            arg_seen[k] = sqrt_arg;
          end
          if (mag_we) begin
            k = wr_cnt % N;
            chk("mag_addr", 32'(mag_addr), 32'(wr_cnt));
            chk("mag_data", mag_data, exp_mag(k));
            data_seen[k] = mag_data;
            wcyc[k] = cyc;
            wr_cnt++;
          end
          if (frame_done) begin
            frames++;
            chk("frame_done_after_last", {31'(wr_cnt), prev_we}, {31'(N), 1'b1});
          end
        end
        if (mag_we) tot_we++;
        prev_we = mag_we;
      end
    join_none

    // reset state
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    n_reset = 1'b1;

    // frame 1: directed corner bins plus random, go pulsed mid-frame
    re_mem[0] = 3;      im_mem[0] = 4;
    re_mem[1] = 0;      im_mem[1] = 0;
    re_mem[2] = -32768; im_mem[2] = -32768;
    re_mem[3] = 1;      im_mem[3] = 0;
    re_mem[4] = 4097;   im_mem[4] = 0;
    run_frame(0);
    repeat (500) @(negedge clk);
    go = 1'b1;
    @(negedge clk) go = 1'b0;
    chk("busy_mid_frame", 32'(busy), 32'd1);
    wait_done(20000);
    chk("start_count_f1", 32'(starts), 32'(nz_count()));
    chk("arg_3_4", arg_seen[0], 32'h41C8_0000);
    chk("mag_3_4", data_seen[0], 32'h40A0_0000);
    chk("mag_zero_bin", data_seen[1], 32'h0);
    chk("arg_max_neg", arg_seen[2], 32'h4F00_0000);
    chk("arg_one", arg_seen[3], 32'h3F80_0000);
    chk("arg_trunc", arg_seen[4], 32'h4B80_1000);
    @(negedge clk);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
    chk("no_err_f1", 32'(err_timeout), 32'd0);

    // frame 2: random
    fill();
    run_frame(0);
    wait_done(20000);
    chk("start_count_f2", 32'(starts), 32'(nz_count()));

    // frame 3: sqrt unit hangs; every non-zero bin gets qNaN
    fill();
    re_mem[1] = 5;   im_mem[1] = 7;
    re_mem[2] = 100; im_mem[2] = -3;
    run_frame(1);
    wait_done(20000);
    chk("err_set", 32'(err_timeout), 32'd1);
    chk("start_timeout_gap", 32'(wcyc[2] - wcyc[1]), 32'(TMO + 6));
    stuck_frame = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_sticky", 32'(err_timeout), 32'd1);

    // frame 4: err cleared by go (checked in run_frame), normal frame
    fill();
    run_frame(0);
    wait_done(20000);
    chk("start_count_f4", 32'(starts), 32'(nz_count()));
    chk("no_err_f4", 32'(err_timeout), 32'd0);

    // frame 5: reset while waiting on the sqrt unit
    fill();
    re_mem[0] = 9; im_mem[0] = 0;
    run_frame(0);
    i = 0;
    while (starts == 0 && i < 2000) begin @(negedge clk); i++; end
    chk("start_before_reset", 32'(starts != 0), 32'd1);
    repeat (10) @(negedge clk);
    f0 = frames;
    w0 = tot_we;
    n_reset = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (60) @(negedge clk);
    chk("no_stray_we", 32'(tot_we - w0), 32'd0);
    chk("no_frame_done_after_reset", 32'(frames - f0), 32'd0);
    chk("idle_after_reset", 32'(busy), 32'd0);
    fill();
    run_frame(0);
    wait_done(20000);
    chk("start_count_f5", 32'(starts), 32'(nz_count()));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
